// File: rtl/seq_player.sv
`default_nettype none
// ============================================================================
// Module      : seq_player
// Description : Sequence player for the game datapath. Holds a writable table
//               of channel indices and replays the first `length` entries as
//               one-hot channel outputs. Each step is lit for a hold time and
//               followed by a dark gap. Supports single-shot and loop modes,
//               abort, and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_player #(
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 16,
    parameter  int HOLD_W   = 8,
    localparam int CH_W     = $clog2(CHANNELS),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [CH_W-1:0]     wr_data,
    input  logic                start,
    input  logic [AW:0]         length,
    input  logic [HOLD_W-1:0]   hold,
    input  logic [HOLD_W-1:0]   gap,
    input  logic                loop,
    input  logic                abort,
    output logic [CHANNELS-1:0] out,
    output logic [AW-1:0]       step,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [AW:0]         c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0]         c_len_one  = (AW+1)'(1);
    localparam logic [AW-1:0]       c_step_one = AW'(1);
    localparam logic [HOLD_W-1:0]   c_cnt_one  = HOLD_W'(1);
    localparam logic [CHANNELS-1:0] c_ch_one   = CHANNELS'(1);

    // Channel table
    logic [CH_W-1:0]     r_table [DEPTH];

    // Control state and registered outputs
    state_t              r_state;
    logic [CHANNELS-1:0] r_out;
    logic [AW-1:0]       r_step;
    logic                r_busy;
    logic                r_done;
    logic [HOLD_W-1:0]   r_cnt;

    // Playback parameters captured at start
    logic [AW:0]         r_len;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   r_gap;
    logic                r_loop;

    // Next-state values
    state_t              w_state_nxt;
    logic [CHANNELS-1:0] w_out_nxt;
    logic [AW-1:0]       w_step_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [HOLD_W-1:0]   w_cnt_nxt;
    logic [AW:0]         w_len_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [HOLD_W-1:0]   w_gap_nxt;
    logic                w_loop_nxt;

    // Helpers
    logic [AW:0]         w_len_clamp;
    logic [HOLD_W-1:0]   w_hold_eff;
    logic [AW-1:0]       w_step_inc;
    logic                w_last;
    logic [CHANNELS-1:0] w_oh_first;
    logic [CHANNELS-1:0] w_oh_next;
    logic                w_adv;
    logic                w_stop;

    assign w_len_clamp = (length > c_depth) ? c_depth : length;
    assign w_hold_eff  = (hold == '0) ? c_cnt_one : hold;
    assign w_step_inc  = r_step + c_step_one;
    assign w_last      = ({1'b0, r_step} == (r_len - c_len_one));
    // The table is only sampled on entry to ON, so a lit step keeps its
    // channel even if its entry is rewritten while it is displayed.
    assign w_oh_first  = c_ch_one << r_table[0];
    assign w_oh_next   = c_ch_one << r_table[w_step_inc];

    // Table storage: reset reloads entry i with i mod CHANNELS; writes accepted in any state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CH_W'(i);
            end
        end else if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Playback state register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_hold  <= '0;
            r_gap   <= '0;
            r_loop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_step  <= w_step_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_hold  <= w_hold_nxt;
            r_gap   <= w_gap_nxt;
            r_loop  <= w_loop_nxt;
        end
    end

    // Next-state and next-output logic; abort outranks the end-of-step advance
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_step_nxt  = r_step;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_hold_nxt  = r_hold;
        w_gap_nxt   = r_gap;
        w_loop_nxt  = r_loop;
        w_adv       = 1'b0;
        w_stop      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_clamp != '0) begin
                        w_len_nxt   = w_len_clamp;
                        w_hold_nxt  = w_hold_eff;
                        w_gap_nxt   = gap;
                        w_loop_nxt  = loop;
                        w_state_nxt = S_ON;
                        w_step_nxt  = '0;
                        w_out_nxt   = w_oh_first;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = w_hold_eff - c_cnt_one;
                    end else begin
                        // Empty sequence: report completion without playing
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (abort) begin
                    w_stop = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_gap != '0) begin
                    w_state_nxt = S_GAP;
                    w_out_nxt   = '0;
                    w_cnt_nxt   = r_gap - c_cnt_one;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_stop = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    w_adv = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_step_nxt  = '0;
        end

        if (w_adv) begin
            if (!w_last) begin
                w_state_nxt = S_ON;
                w_step_nxt  = w_step_inc;
                w_out_nxt   = w_oh_next;
                w_cnt_nxt   = r_hold - c_cnt_one;
            end else if (r_loop) begin
                w_state_nxt = S_ON;
                w_step_nxt  = '0;
                w_out_nxt   = w_oh_first;
                w_cnt_nxt   = r_hold - c_cnt_one;
            end else begin
                w_state_nxt = S_IDLE;
                w_out_nxt   = '0;
                w_step_nxt  = '0;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
        end
    end

    assign out  = r_out;
    assign step = r_step;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_player
// Description : Scoreboard testbench for seq_player. Stimulus pushes the
//               expected per-cycle output for every cycle in which busy or
//               done should be high; a monitor pops and compares whenever the
//               DUT shows busy or done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_player;

    localparam int CHANNELS = 4;
    localparam int DEPTH    = 16;
    localparam int HOLD_W   = 8;
    localparam int CH_W     = 2;
    localparam int AW       = 4;

    logic                clock   = 1'b0;
    logic                reset   = 1'b1;
    logic                wr_en   = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [CH_W-1:0]     wr_data = '0;
    logic                start   = 1'b0;
    logic [AW:0]         length  = '0;
    logic [HOLD_W-1:0]   hold    = '0;
    logic [HOLD_W-1:0]   gap     = '0;
    logic                loop    = 1'b0;
    logic                abort   = 1'b0;
    logic [CHANNELS-1:0] out;
    logic [AW-1:0]       step;
    logic                busy;
    logic                done;

    seq_player #(
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .length  (length),
        .hold    (hold),
        .gap     (gap),
        .loop    (loop),
        .abort   (abort),
        .out     (out),
        .step    (step),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                  cyc;
        logic [CHANNELS-1:0] out;
        logic [AW-1:0]       step;
        logic                busy;
        logic                done;
    } exp_t;

    exp_t            q[$];
    exp_t            mon_e;
    int              n_checks = 0;
    int              n_errs   = 0;
    logic [CH_W-1:0] tbl [DEPTH];

    function automatic logic [CHANNELS-1:0] oh(input logic [CH_W-1:0] c);
        logic [CHANNELS-1:0] one;
        one = CHANNELS'(1);
        return one << c;
    endfunction

    task automatic push_exp(input int c, input logic [CHANNELS-1:0] o,
                            input int s, input logic b, input logic d);
        exp_t e;
        e.cyc  = c;
        e.out  = o;
        e.step = AW'(s);
        e.busy = b;
        e.done = d;
        q.push_back(e);
    endtask

    // Single-shot playback of n steps started in cycle t0; entries beyond
    // t0+upto are not pushed (used when reset cuts a playback short).
    task automatic push_play(input int t0, input int n, input int h,
                             input int g, input int upto);
        int c;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++) begin
                c = t0 + 1 + k * (h + g) + i;
                if (c <= t0 + upto) push_exp(c, oh(tbl[k]), k, 1'b1, 1'b0);
            end
            for (int i = 0; i < g; i++) begin
                c = t0 + 1 + k * (h + g) + h + i;
                if (c <= t0 + upto) push_exp(c, '0, k, 1'b1, 1'b0);
            end
        end
        c = t0 + 1 + n * (h + g);
        if (c <= t0 + upto) push_exp(c, '0, 0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic do_start(input int len, input int h, input int g, input logic lp);
        length = (AW+1)'(len);
        hold   = HOLD_W'(h);
        gap    = HOLD_W'(g);
        loop   = lp;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic write_tbl(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = CH_W'(d);
        @(negedge clock);
        wr_en   = 1'b0;
        tbl[a]  = CH_W'(d);
    endtask

    task automatic model_reset_tbl();
        for (int i = 0; i < DEPTH; i++) tbl[i] = CH_W'(i % CHANNELS);
    endtask

    task automatic tb_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset_tbl();
    endtask

    // Monitor: every cycle with busy or done must match the next expected entry
    always @(negedge clock) begin
        if (busy === 1'b1 || done === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errs++;
                $display("FAIL unexpected_output cycle=%0d out=%b step=%0d busy=%b done=%b (nothing expected)",
                         cyc, out, step, busy, done);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc || out !== mon_e.out || busy !== mon_e.busy ||
                    done !== mon_e.done || (mon_e.busy && step !== mon_e.step)) begin
                    n_errs++;
                    $display("FAIL scoreboard cycle=%0d/%0d out=%b/%b step=%0d/%0d busy=%b/%b done=%b/%b (actual/required)",
                             cyc, mon_e.cyc, out, mon_e.out, step, mon_e.step,
                             busy, mon_e.busy, done, mon_e.done);
                end
            end
        end
    end

    initial begin
        int t0;
        model_reset_tbl();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        chk("reset_out",  32'(out),  32'd0);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // 1: len=4 hold=2 gap=1 single shot, done at cycle 13
        t0 = cyc;
        push_play(t0, 4, 2, 1, 1000);
        do_start(4, 2, 1, 1'b0);
        repeat (16) @(negedge clock);
        chk("t1_drained", 32'(q.size()), 32'd0);

        // 2: rewritten table, hold=1; restart on the done cycle with hold=0
        write_tbl(0, 3);
        write_tbl(1, 0);
        t0 = cyc;
        push_play(t0, 2, 1, 0, 1000);
        do_start(2, 1, 0, 1'b0);
        repeat (2) @(negedge clock);
        t0 = cyc;
        push_play(t0, 2, 1, 0, 1000);
        do_start(2, 0, 0, 1'b0);
        repeat (4) @(negedge clock);
        chk("t2_drained", 32'(q.size()), 32'd0);

        // 3: loop len=3, then abort
        tb_reset();
        t0 = cyc;
        for (int k = 0; k < 7; k++) push_exp(t0 + 1 + k, oh(tbl[k % 3]), k % 3, 1'b1, 1'b0);
        do_start(3, 1, 0, 1'b1);
        repeat (6) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_out",  32'(out),  32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_step", 32'(step), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (5) @(negedge clock);
        chk("t3_drained", 32'(q.size()), 32'd0);

        // Abort together with start in IDLE: start wins
        t0 = cyc;
        push_play(t0, 1, 1, 0, 1000);
        abort = 1'b1;
        do_start(1, 1, 0, 1'b0);
        abort = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_start_drained", 32'(q.size()), 32'd0);

        // 4: length=0 gives done in cycle 1, no busy
        t0 = cyc;
        push_exp(t0 + 1, '0, 0, 1'b0, 1'b1);
        do_start(0, 1, 0, 1'b0);
        repeat (3) @(negedge clock);
        chk("len0_drained", 32'(q.size()), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);

        // length=20 clamps to 16 steps, done in cycle 17
        t0 = cyc;
        push_play(t0, 16, 1, 0, 1000);
        do_start(20, 1, 0, 1'b0);
        repeat (18) @(negedge clock);
        chk("len20_drained", 32'(q.size()), 32'd0);

        // 5: start mid-playback is ignored
        t0 = cyc;
        push_play(t0, 4, 2, 1, 1000);
        do_start(4, 2, 1, 1'b0);
        repeat (4) @(negedge clock);
        length = 5'd1;
        hold   = 8'd5;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        repeat (9) @(negedge clock);
        chk("restart_ignored_drained", 32'(q.size()), 32'd0);

        // Reset mid-playback reloads the table
        write_tbl(0, 2);
        t0 = cyc;
        push_play(t0, 4, 2, 1, 5);
        do_start(4, 2, 1, 1'b0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset_tbl();
        chk("midreset_out",  32'(out),  32'd0);
        chk("midreset_step", 32'(step), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_drained", 32'(q.size()), 32'd0);
        t0 = cyc;
        push_play(t0, 1, 1, 0, 1000);
        do_start(1, 1, 0, 1'b0);
        chk("reload_entry0", 32'(out), 32'b0001);
        repeat (3) @(negedge clock);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_player.md
# seq_player

Parametrised sequence player for the game datapath. Holds a writable table of DEPTH channel indices and replays the first `length` entries as one-hot channel outputs, each lit for a programmable hold time and followed by a programmable dark gap. Supports single-shot and loop modes, abort, and a done pulse. Drives the channel LEDs/tones, and the round controller grows `length` each round.

## Interface
- CHANNELS, 4: number of one-hot output channels; power of two, at least 2.
- DEPTH, 16: table entries; power of two, at least 2.
- HOLD_W, 8: width of the hold and gap counters.
- CH_W, clog2(CHANNELS): width of a table entry (derived).
- AW, clog2(DEPTH): table address width (derived).

- clock, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high.
- wr_en, in, 1: table write strobe.
- wr_addr, in, AW: table write address.
- wr_data, in, CH_W: channel index to store.
- start, in, 1: begin playback; sampled in IDLE only.
- length, in, AW+1: number of steps to play; 0 means no steps; values above DEPTH are clamped to DEPTH.
- hold, in, HOLD_W: cycles each step is lit; 0 is treated as 1.
- gap, in, HOLD_W: dark cycles after each step; 0 means no gap.
- loop, in, 1: 1 = repeat indefinitely; 0 = single shot.
- abort, in, 1: stop playback.
- out, out, CHANNELS: one-hot active channel; all zeros when dark.
- step, out, AW: index of the current step.
- busy, out, 1: playback in progress.
- done, out, 1: one-cycle pulse at the end of a single-shot playback.

## Operation
- Reset:
  - out = 0, step = 0, busy = 0, done = 0, state = IDLE.
  - Table entry i is reloaded with i mod CHANNELS.
- Table:
  - A write with wr_en = 1 takes effect at the next edge and is accepted in any state.
  - `out` loads from the table only on entry to ON. A write to the step currently lit does not change `out` until that step is next entered.
- Latching: on accepted start, latch min(length, DEPTH), max(hold, 1), gap and loop. Input changes during playback are ignored.
- IDLE:
  - start = 1 with clamped length ≥ 1: go to ON, step = 0.
  - start = 1 with length = 0: done = 1 next cycle, busy stays 0, remain in IDLE.
- ON:
  - out = onehot(table[step]) for hold cycles.
  - Then go to GAP if gap > 0, otherwise advance.
- GAP: out = 0 for gap cycles, then advance.
- Advance:
  - If step < len−1: step+1, go to ON.
  - Else if loop = 1: step = 0, go to ON.
  - Else go to IDLE, with busy = 0 and done = 1 for one cycle.
- Abort: from ON or GAP, the next cycle gives IDLE, out = 0, busy = 0, step = 0, and no done pulse. Abort has priority over advance in the same cycle. Abort in IDLE has no effect.
- start while busy is ignored.
- Abort and start in the same IDLE cycle: start wins.
- Reset mid-playback: same as power-on reset, including the table reload.

## Timing
- start is sampled at edge 0. Step k is lit from cycle 1 + k·(H+G) for H cycles, where H = max(hold, 1) and G = gap.
- busy = 1 from cycle 1 through cycle len·(H+G).
- done = 1 and busy = 0 in cycle 1 + len·(H+G).
- A new start is accepted in the same cycle as done.
- All outputs are registered. There is no combinational path from inputs to outputs.
- step is valid whenever busy = 1, and holds its value during GAP.

## Test plan
1. Reset, then start with length=4, hold=2, gap=1, loop=0 -> out is 0001, 0010, 0100, 1000, each for 2 cycles with one zero cycle between them; done pulses at cycle 13.
2. Write table[0]=3 and table[1]=0, then start with length=2, hold=1, gap=0 -> out=1000 in cycle 1, out=0001 in cycle 2, done in cycle 3. hold=0 gives identical results.
3. loop=1, length=3, hold=1, gap=0 -> out cycles 0001, 0010, 0100, 0001, … with no done pulse. Assert abort -> next cycle out=0, busy=0, step=0, and done is never pulsed.
4. start with length=0 -> done pulse in cycle 1 and busy never rises. length=20 with hold=1, gap=0 -> 16 steps, step runs 0..15, done in cycle 17.
5. Pulse start again mid-playback -> ignored and timing unchanged. Assert reset mid-playback -> next cycle all outputs are 0 and table entry 0 reads back as the default (playback then shows 0001).
